// File: rtl/round_timer_pkg.sv
// Shared types and constants for the round timer.
// Optional warning output is enabled with ROUND_TIMER_WARN_EN.
package timer_pkg;

    typedef enum logic [1:0] {
        RT_IDLE,
        RT_RUN,
        RT_PAUSED,
        RT_DONE
    } rt_state_t;

    // Real-board clock is 1.28 us, so this many cycles make one second.
    localparam int CLK_TICKS_PER_SEC = 781250;
    // Short second used by simulation benches.
    localparam int TB_TICKS_PER_SEC  = 4;

    // True when a seconds value lies inside the last-seconds warning window.
    function automatic logic in_warn_window(input int unsigned sec, input int unsigned warn_sec);
        return (sec != 0) && (sec <= warn_sec);
    endfunction

endpackage

// File: rtl/round_timer_if.sv
// Control/status bundle between the game-control FSM (master) and the
// round timer (slave). The warn line exists only with ROUND_TIMER_WARN_EN.
interface round_timer_if #(
    parameter int SEC_WIDTH = 7
);
    logic                 start;
    logic                 pause;
    logic                 abort;
    logic                 periodic;
    logic [SEC_WIDTH-1:0] load_sec;
    logic                 ready;
    logic                 running;
    logic                 tick_1s;
    logic                 expired;
    logic [SEC_WIDTH-1:0] sec_left;
`ifdef ROUND_TIMER_WARN_EN
    logic                 warn;
`endif

    modport master (
        output start, pause, abort, periodic, load_sec,
`ifdef ROUND_TIMER_WARN_EN
        input  warn,
`endif
        input  ready, running, tick_1s, expired, sec_left
    );

    modport slave (
        input  start, pause, abort, periodic, load_sec,
`ifdef ROUND_TIMER_WARN_EN
        output warn,
`endif
        output ready, running, tick_1s, expired, sec_left
    );

endinterface

// File: rtl/round_timer_sec_prescaler.sv
// Clock-cycle prescaler: counts enabled cycles and flags the last cycle
// of each second. clear restarts the second from zero.
module sec_prescaler #(
    parameter int TICKS_PER_SEC = 4,
    parameter int PRE_WIDTH     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam logic [PRE_WIDTH-1:0] TERMINAL = PRE_WIDTH'(TICKS_PER_SEC - 1);

    logic [PRE_WIDTH-1:0] count_reg;

    // Terminal count is flagged combinationally; the consumer registers it.
    assign tick = enable && (count_reg == TERMINAL);

    // Count enabled cycles, wrapping to zero after the terminal count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            if (count_reg == TERMINAL) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + PRE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/round_timer.sv
// Programmable seconds countdown with start/pause/abort, one-shot or
// periodic reload, seconds readout and single-cycle expiry pulse.
// Define ROUND_TIMER_WARN_EN to add the WARN_SEC parameter and warn output.
module round_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = CLK_TICKS_PER_SEC,
    parameter int SEC_WIDTH     = 7
`ifdef ROUND_TIMER_WARN_EN
    ,
    parameter int WARN_SEC      = 10
`endif
) (
    input  logic           clk,
    input  logic           reset,
    round_timer_if.slave   bus
);
    // A one-cycle second still needs a one-bit counter.
    localparam int PRE_WIDTH = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    rt_state_t            state_reg;
    logic [SEC_WIDTH-1:0] sec_left_reg;
    logic [SEC_WIDTH-1:0] reload_reg;
    logic                 ready_reg;
    logic                 running_reg;
    logic                 tick_reg;
    logic                 expired_reg;
    logic                 pre_tick;
    logic                 pre_clear;
    logic                 pre_enable;
`ifdef ROUND_TIMER_WARN_EN
    logic                 warn_reg;
`endif

    // A new load or an abort always restarts the second from zero.
    assign pre_clear  = bus.start || bus.abort;
    assign pre_enable = (state_reg == RT_RUN);

    sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .PRE_WIDTH     (PRE_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (pre_clear),
        .enable (pre_enable),
        .tick   (pre_tick)
    );

    // Control FSM; every output is updated alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RT_IDLE;
            sec_left_reg <= '0;
            reload_reg   <= '0;
            ready_reg    <= 1'b1;
            running_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            expired_reg  <= 1'b0;
`ifdef ROUND_TIMER_WARN_EN
            warn_reg     <= 1'b0;
`endif
        end else begin
            tick_reg    <= 1'b0;
            expired_reg <= 1'b0;
            if (bus.abort) begin
                state_reg    <= RT_IDLE;
                sec_left_reg <= '0;
                ready_reg    <= 1'b1;
                running_reg  <= 1'b0;
`ifdef ROUND_TIMER_WARN_EN
                warn_reg     <= 1'b0;
`endif
            end else if (bus.start) begin
                reload_reg <= bus.load_sec;
                if (bus.load_sec == '0) begin
                    // Zero-length round expires immediately.
                    state_reg    <= RT_DONE;
                    sec_left_reg <= '0;
                    expired_reg  <= 1'b1;
                    ready_reg    <= 1'b1;
                    running_reg  <= 1'b0;
`ifdef ROUND_TIMER_WARN_EN
                    warn_reg     <= 1'b0;
`endif
                end else begin
                    state_reg    <= RT_RUN;
                    sec_left_reg <= bus.load_sec;
                    ready_reg    <= 1'b0;
                    running_reg  <= 1'b1;
`ifdef ROUND_TIMER_WARN_EN
                    warn_reg     <= in_warn_window(32'(bus.load_sec), WARN_SEC);
`endif
                end
            end else begin
                case (state_reg)
                    RT_RUN: begin
                        if (pre_tick) begin
                            tick_reg <= 1'b1;
                            if (sec_left_reg == SEC_WIDTH'(1)) begin
                                expired_reg <= 1'b1;
                                if (bus.periodic) begin
                                    sec_left_reg <= reload_reg;
                                    state_reg    <= bus.pause ? RT_PAUSED : RT_RUN;
`ifdef ROUND_TIMER_WARN_EN
                                    warn_reg     <= in_warn_window(32'(reload_reg), WARN_SEC);
`endif
                                end else begin
                                    state_reg    <= RT_DONE;
                                    sec_left_reg <= '0;
                                    ready_reg    <= 1'b1;
                                    running_reg  <= 1'b0;
`ifdef ROUND_TIMER_WARN_EN
                                    warn_reg     <= 1'b0;
`endif
                                end
                            end else begin
                                if (sec_left_reg != '0) begin
                                    sec_left_reg <= sec_left_reg - SEC_WIDTH'(1);
                                end
                                state_reg <= bus.pause ? RT_PAUSED : RT_RUN;
`ifdef ROUND_TIMER_WARN_EN
                                warn_reg  <= in_warn_window(32'(sec_left_reg - SEC_WIDTH'(1)), WARN_SEC);
`endif
                            end
                        end else if (bus.pause) begin
                            state_reg <= RT_PAUSED;
                        end
                    end
                    RT_PAUSED: begin
                        if (!bus.pause) begin
                            state_reg <= RT_RUN;
                        end
                    end
                    default: begin
                        // IDLE and DONE hold until start or abort.
                    end
                endcase
            end
        end
    end

    assign bus.ready    = ready_reg;
    assign bus.running  = running_reg;
    assign bus.tick_1s  = tick_reg;
    assign bus.expired  = expired_reg;
    assign bus.sec_left = sec_left_reg;
`ifdef ROUND_TIMER_WARN_EN
    assign bus.warn     = warn_reg;
`endif

endmodule
